// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Word-organised data memory behind a valid/ready request port with a fixed
// number of wait states before a one-cycle response strobe. It handles
// RV32 byte/half/word loads (sign- or zero-extended) and byte/half/word
// stores with per-byte lane enables. Memory is little-endian.
//
// Build option: define DMEM_MISALIGN_ERR_EN to flag misaligned half/word
// accesses as errors. When it is undefined, misaligned half/word addresses
// are forced to natural alignment and never raise err.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : responder idle and able to accept
//   memread    : request is a load
//   memwrite   : request is a store
//   funct[2:0] : RV32 funct3 size/sign code
//   addr[31:0] : byte address
//   wdata[31:0]: store data, low-aligned
//   resp_valid : one-cycle response strobe
//   rdata[31:0]: load result (0 for stores and errors), held between responses
//   err        : response is an error, qualified by resp_valid
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_rd;
  logic        r_wr;
  logic [2:0]  r_funct;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_rd;
  logic          w_wr;
  logic [2:0]    w_funct;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_fn_ok;
  logic          w_oor;
  logic          w_mis;
  logic          w_err;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [3:0]    w_be;
  logic [31:0]   w_sdata;

  // Extract and extend the addressed byte/half from a memory word.
  function automatic logic [31:0] f_load(input logic [31:0] word,
                                         input logic [2:0]  fn,
                                         input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (fn)
      3'b000:  f_load = {{24{b[7]}}, b};
      3'b001:  f_load = {{16{h[15]}}, h};
      3'b010:  f_load = word;
      3'b100:  f_load = {24'h0, b};
      3'b101:  f_load = {16'h0, h};
      default: f_load = 32'h0;
    endcase
  endfunction

  // Byte-lane enables for a store.
  function automatic logic [3:0] f_store_be(input logic [2:0] fn,
                                            input logic [1:0] lane);
    case (fn)
      3'b000:  f_store_be = 4'b0001 << lane;
      3'b001:  f_store_be = lane[1] ? 4'b1100 : 4'b0011;
      3'b010:  f_store_be = 4'b1111;
      default: f_store_be = 4'b0000;
    endcase
  endfunction

  // Store data replicated across lanes so the enables pick the right copy.
  function automatic logic [31:0] f_store_data(input logic [2:0]  fn,
                                               input logic [31:0] wd);
    case (fn)
      3'b000:  f_store_data = {4{wd[7:0]}};
      3'b001:  f_store_data = {2{wd[15:0]}};
      default: f_store_data = wd;
    endcase
  endfunction

  // Including reset keeps ready low while reset is held, even though the
  // state register already reads IDLE.
  assign req_ready = (r_state == S_IDLE) && reset;
  assign w_accept  = req_valid && req_ready && (memread || memwrite);

  // With zero wait states the response is computed on the accepting edge
  // itself, so the operation comes straight from the ports in IDLE.
  assign w_rd    = (r_state == S_IDLE) ? memread  : r_rd;
  assign w_wr    = (r_state == S_IDLE) ? memwrite : r_wr;
  assign w_funct = (r_state == S_IDLE) ? funct    : r_funct;
  assign w_addr  = (r_state == S_IDLE) ? addr     : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? wdata    : r_wdata;

  assign w_enter_resp = ((r_state == S_IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  always_comb begin
    w_fn_ok = 1'b0;
    if (w_rd)
      w_fn_ok = (w_funct == 3'b000) || (w_funct == 3'b001) || (w_funct == 3'b010) ||
                (w_funct == 3'b100) || (w_funct == 3'b101);
    else
      w_fn_ok = (w_funct == 3'b000) || (w_funct == 3'b001) || (w_funct == 3'b010);
  end

  assign w_oor = (w_addr[31:AW+2] != '0);

`ifdef DMEM_MISALIGN_ERR_EN
  // funct[1:0]==01 covers LH, LHU and SH.
  assign w_mis = ((w_funct[1:0] == 2'b01) && w_addr[0]) ||
                 ((w_funct == 3'b010) && (w_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_err    = (w_rd && w_wr) || !w_fn_ok || w_oor || w_mis;
  assign w_idx    = w_addr[AW+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_be     = f_store_be(w_funct, w_addr[1:0]);
  assign w_sdata  = f_store_data(w_funct, w_wdata);
  assign w_commit = w_enter_resp && w_wr && !w_err;

  // Request capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_funct <= funct;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // Memory array: not reset; commit only on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_sdata[8*b +: 8];
      end
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      resp_valid <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd <= memread;
            r_wr <= memwrite;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_M1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_enter_resp) begin
        resp_valid <= 1'b1;
        err        <= w_err;
        rdata      <= (w_err || !w_rd) ? 32'h0 : f_load(w_word, w_funct, w_addr[1:0]);
      end
    end
  end

endmodule
